// File: rtl/ram_pkg.sv
// Shared types and default sizes for the parametrised RAM block.
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  localparam int RAM_WIDTH  = 16;
  localparam int RAM_ADDR_W = 6;

endpackage

// File: rtl/ram_array.sv
// Reset-free storage: one write port and one registered, read-first read port.
module ram_array
  import ram_pkg::*;
#(
  parameter int WIDTH  = RAM_WIDTH,
  parameter int ADDR_W = RAM_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Non-blocking read and write in one process: a same-address read sees the old word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_param.sv
// WIDTH x 2**ADDR_W RAM with registered read, read-valid strobe and a zero-fill sweep engine.
module ram_param
  import ram_pkg::*;
#(
  parameter int WIDTH          = RAM_WIDTH,
  parameter int ADDR_W         = RAM_ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic              rd_en,
  input  logic              clear,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam state_e            RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              vld_q, vld_d;
  logic              rd_seen_q, rd_seen_d;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              re;
  logic [WIDTH-1:0]  rdata;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    vld_d      = 1'b0;
    rd_seen_d  = rd_seen_q;
    we         = 1'b0;
    waddr      = address;
    wdata      = in;
    re         = 1'b0;
    case (state_q)
      IDLE: begin
        if (clear) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
        end else begin
          we    = load;
          re    = rd_en;
          vld_d = rd_en;
          if (rd_en) begin
            rd_seen_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_addr_q;
        wdata = '0;
        // Leave on the last word rather than wrapping, so a sweep never repeats.
        if (clr_addr_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          clr_addr_d = clr_addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RST_STATE;
      clr_addr_q <= '0;
      vld_q      <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      vld_q      <= vld_d;
      rd_seen_q  <= rd_seen_d;
    end
  end

  ram_array #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .re   (re),
    .raddr(address),
    .rdata(rdata)
  );

  // The read register has no reset; out reads as zero until a read lands after reset.
  assign out       = rd_seen_q ? rdata : '0;
  assign out_valid = vld_q;
  assign busy      = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_param.sv
// Scoreboard bench for ram_param: a behavioural model predicts read data, busy and hold behaviour.
module tb_ram_param;

  localparam int W     = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, load, rd_en, clear, out_valid, busy;
  logic [W-1:0]  in, out;
  logic [AW-1:0] address;

  logic          reset2, load2, rd_en2, clear2, out_valid2, busy2;
  logic [W-1:0]  in2, out2;
  logic [AW-1:0] address2;

  ram_param #(.WIDTH(W), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .in(in), .address(address), .load(load),
    .rd_en(rd_en), .clear(clear), .out(out), .out_valid(out_valid), .busy(busy)
  );

  ram_param #(.WIDTH(W), .ADDR_W(AW), .CLEAR_ON_RESET(1'b0)) dut2 (
    .clk(clk), .reset(reset2), .in(in2), .address(address2), .load(load2),
    .rd_en(rd_en2), .clear(clear2), .out(out2), .out_valid(out_valid2), .busy(busy2)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] sb_q[$];
  logic [W-1:0] mdl[DEPTH];
  logic [W-1:0] mdl_out;
  int           mdl_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every read strobe must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb_q.size() == 0) chk("unexp_vld", 32'd1, 32'd0);
      else chk("rd_data", {16'd0, out}, {16'd0, sb_q.pop_front()});
    end
  end

  task automatic model_zero();
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
  endtask

  // One clock of stimulus, driven at the falling edge and checked at the next one.
  task automatic cyc(input logic ld, input logic rd, input logic cl,
                     input logic [AW-1:0] a, input logic [W-1:0] d);
    logic exp_vld;
    exp_vld = 1'b0;
    load = ld; rd_en = rd; clear = cl; address = a; in = d;
    chk("busy", {31'd0, busy}, {31'd0, mdl_cnt != 0});
    if (mdl_cnt == 0) begin
      if (cl) begin
        mdl_cnt = DEPTH;
        model_zero();
      end else begin
        if (rd) begin
          sb_q.push_back(mdl[a]);
          mdl_out = mdl[a];
          exp_vld = 1'b1;
        end
        if (ld) mdl[a] = d;
      end
    end else begin
      mdl_cnt--;
    end
    @(posedge clk);
    @(negedge clk);
    chk("vld", {31'd0, out_valid}, {31'd0, exp_vld});
    if (!exp_vld) chk("hold", {16'd0, out}, {16'd0, mdl_out});
    load = 1'b0; rd_en = 1'b0; clear = 1'b0;
  endtask

  task automatic wait_idle(input int inject, output int n);
    n = 0;
    while (busy && n < 200) begin
      if (inject != 0 && n == 3) cyc(1'b1, 1'b1, 1'b0, 6'd9, 16'hDEAD);
      else if (inject != 0 && n == 7) cyc(1'b0, 1'b0, 1'b1, 6'd0, 16'h0);
      else cyc(1'b0, 1'b0, 1'b0, 6'd0, 16'h0);
      n++;
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; load = 0; rd_en = 0; clear = 0; address = '0; in = '0;
    reset2 = 1'b1; load2 = 0; rd_en2 = 0; clear2 = 0; address2 = '0; in2 = '0;
    mdl_out = '0;
    mdl_cnt = 0;
    model_zero();

    repeat (3) @(negedge clk);
    chk("rst_out", {16'd0, out}, 32'd0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    mdl_cnt = DEPTH;
    wait_idle(0, n);
    chk("busy_len_rst", n, DEPTH);

    cyc(0, 1, 0, 6'd0, 16'h0);
    cyc(0, 1, 0, 6'd37, 16'h0);
    cyc(0, 1, 0, 6'd63, 16'h0);

    cyc(1, 0, 0, 6'd5, 16'hBEEF);
    cyc(0, 1, 0, 6'd5, 16'h0);
    cyc(0, 0, 0, 6'd0, 16'h0);
    cyc(1, 1, 0, 6'd5, 16'h1234);
    cyc(0, 1, 0, 6'd5, 16'h0);
    cyc(0, 0, 0, 6'd0, 16'h0);

    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, i[AW-1:0], 16'(i));
    cyc(0, 1, 0, 6'd42, 16'h0);
    cyc(1, 1, 1, 6'd3, 16'h5555);
    wait_idle(1, n);
    chk("busy_len_clr", n, DEPTH);
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 0, i[AW-1:0], 16'h0);

    cyc(1, 0, 0, 6'd10, 16'hBEEF);
    cyc(0, 1, 0, 6'd10, 16'h0);
    cyc(0, 0, 1, 6'd0, 16'h0);
    repeat (20) cyc(0, 0, 0, 6'd0, 16'h0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_out", {16'd0, out}, 32'd0);
    chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd1);
    mdl_out = '0;
    @(negedge clk);
    reset = 1'b0;
    mdl_cnt = DEPTH;
    model_zero();
    wait_idle(0, n);
    chk("busy_len_mid", n, DEPTH);
    cyc(0, 1, 0, 6'd10, 16'h0);
    cyc(0, 1, 0, 6'd0, 16'h0);
    cyc(0, 0, 0, 6'd0, 16'h0);
    chk("sb_empty", sb_q.size(), 32'd0);

    chk("r2_rst_out", {16'd0, out2}, 32'd0);
    chk("r2_rst_vld", {31'd0, out_valid2}, 32'd0);
    reset2 = 1'b0;
    #1;
    chk("r2_busy", {31'd0, busy2}, 32'd0);
    load2 = 1'b1; address2 = 6'd63; in2 = 16'hA5A5;
    @(posedge clk);
    @(negedge clk);
    load2 = 1'b0; rd_en2 = 1'b1;
    chk("r2_vld_wr", {31'd0, out_valid2}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rd_en2 = 1'b0;
    chk("r2_out", {16'd0, out2}, 32'h0000A5A5);
    chk("r2_vld", {31'd0, out_valid2}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    chk("r2_vld_drop", {31'd0, out_valid2}, 32'd0);
    chk("r2_hold", {16'd0, out2}, 32'h0000A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
